// File: rtl/demux_pkg.sv
// Shared types and helpers for the stream demultiplexer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package demux_pkg;

  // Upper bound on the number of output channels the demux supports.
  localparam int MAX_OUT = 16;

  // Packet routing state: IDLE takes the route from in_sel, PKT holds it.
  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

  // Smallest r with 2**r >= n; used to size the select field.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/demux_onehot_dec.sv
// Binary select to one-hot channel decode with a range flag.
// Latency: combinational.
// Backpressure: not applicable.
module demux_onehot_dec #(
  parameter int N_OUT = 8,
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0] sel,
  output logic [N_OUT-1:0] onehot,
  output logic             in_range
);

  // One bit per existing channel; a select past the last channel sets none.
  always_comb begin
    onehot = '0;
    for (int k = 0; k < N_OUT; k++) begin
      onehot[k] = (sel == SEL_W'(k));
    end
  end

  assign in_range = |onehot;

endmodule

// File: rtl/stream_demux.sv
// 1-to-N valid/ready stream demux with optional per-packet route locking.
// Latency: an accepted beat appears on its channel one clock later.
// Backpressure: single holding register; a stalled channel stalls the input.
module stream_demux
  import demux_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int N_OUT    = 8,
  parameter  int LOCK_PKT = 1,
  localparam int SEL_W    = clog2(N_OUT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_last,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic [N_OUT-1:0]       out_last,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic                   err_sel,
  output logic                   busy
);

  // Holding register; the destination is kept already decoded to one-hot
  // so the output valids and the stall check need no further decode.
  logic [WIDTH-1:0] hold_data;
  logic             hold_last;
  logic [N_OUT-1:0] hold_dest;
  logic             hold_full;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] locked_sel, locked_sel_nxt;

  logic [SEL_W-1:0] route;
  logic [N_OUT-1:0] route_hot;
  logic             route_ok;
  logic             accept;
  logic             drain;

  // Inside a packet the latched route wins; in_sel is ignored.
  assign route = (state == PKT) ? locked_sel : in_sel;

  demux_onehot_dec #(
    .N_OUT (N_OUT),
    .SEL_W (SEL_W)
  ) u_route_dec (
    .sel      (route),
    .onehot   (route_hot),
    .in_range (route_ok)
  );

  // The register is free when empty or when its beat leaves this cycle.
  assign drain    = hold_full && (|(out_ready & hold_dest));
  assign in_ready = !hold_full || (|(out_ready & hold_dest));
  assign accept   = in_valid && in_ready;
  assign busy     = (state == PKT);

  assign out_valid = hold_full ? hold_dest : '0;

  // Only the addressed channel carries data; every other channel reads zero.
  always_comb begin
    out_data = '0;
    out_last = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (out_valid[k]) begin
        out_data[k*WIDTH +: WIDTH] = hold_data;
        out_last[k]                = hold_last;
      end
    end
  end

  // Route-lock FSM: latch the select on a packet's first beat, release on last.
  always_comb begin
    state_nxt      = state;
    locked_sel_nxt = locked_sel;
    case (state)
      IDLE: begin
        if ((LOCK_PKT != 0) && accept && !in_last) begin
          state_nxt      = PKT;
          locked_sel_nxt = in_sel;
        end
      end
      PKT: begin
        if (accept && in_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state and latched route.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      locked_sel <= '0;
    end else begin
      state      <= state_nxt;
      locked_sel <= locked_sel_nxt;
    end
  end

  // Holding register: load in-range beats, empty on drain, flag dropped beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data <= '0;
      hold_last <= 1'b0;
      hold_dest <= '0;
      hold_full <= 1'b0;
      err_sel   <= 1'b0;
    end else begin
      if (accept && route_ok) begin
        hold_data <= in_data;
        hold_last <= in_last;
        hold_dest <= route_hot;
        hold_full <= 1'b1;
      end else if (drain) begin
        hold_full <= 1'b0;
      end
      err_sel <= accept && !route_ok;
    end
  end

endmodule

// File: tb/tb_stream_demux.sv
module tb_stream_demux;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: 8 channels, per-beat routing.
  logic [7:0]  a_data;
  logic [2:0]  a_sel;
  logic        a_last, a_valid, a_ready, a_err, a_busy;
  logic [63:0] a_odata;
  logic [7:0]  a_olast, a_ovalid, a_oready;

  // Instance B: 6 channels, packet lock.
  logic [7:0]  b_data;
  logic [2:0]  b_sel;
  logic        b_last, b_valid, b_ready, b_err, b_busy;
  logic [47:0] b_odata;
  logic [5:0]  b_olast, b_ovalid, b_oready;

  stream_demux #(.WIDTH(8), .N_OUT(8), .LOCK_PKT(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_sel(a_sel), .in_last(a_last),
    .in_valid(a_valid), .in_ready(a_ready), .out_data(a_odata), .out_last(a_olast),
    .out_valid(a_ovalid), .out_ready(a_oready), .err_sel(a_err), .busy(a_busy));

  stream_demux #(.WIDTH(8), .N_OUT(6), .LOCK_PKT(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_sel(b_sel), .in_last(b_last),
    .in_valid(b_valid), .in_ready(b_ready), .out_data(b_odata), .out_last(b_olast),
    .out_valid(b_ovalid), .out_ready(b_oready), .err_sel(b_err), .busy(b_busy));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0]  ov;
    logic [7:0]  ol;
    logic [63:0] od;
    logic        rdy;
    logic        err;
    logic        busy;
  } obs_t;

  typedef struct {
    int          d;
    logic        v;
    logic [2:0]  s;
    logic        l;
    logic [7:0]  dat;
    logic [7:0]  r;
    logic        x_rdy;
    logic [7:0]  x_ov;
    logic [63:0] x_od;
    logic [7:0]  x_ol;
    logic        x_err;
    logic        x_busy;
  } vec_t;

  vec_t       vt[$];
  logic [8:0] mq[8][$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] sl(input int ch, input logic [7:0] v);
    return 64'(v) << (ch * 8);
  endfunction

  function automatic obs_t observe(input int d);
    obs_t o;
    if (d == 0) begin
      o.ov = a_ovalid; o.ol = a_olast; o.od = a_odata;
      o.rdy = a_ready; o.err = a_err; o.busy = a_busy;
    end else begin
      o.ov = {2'b00, b_ovalid}; o.ol = {2'b00, b_olast}; o.od = {16'h0, b_odata};
      o.rdy = b_ready; o.err = b_err; o.busy = b_busy;
    end
    return o;
  endfunction

  task automatic drive(input int d, input logic v, input logic [2:0] s, input logic l,
                       input logic [7:0] dat, input logic [7:0] r);
    if (d == 0) begin
      a_valid = v; a_sel = s; a_last = l; a_data = dat; a_oready = r;
    end else begin
      b_valid = v; b_sel = s; b_last = l; b_data = dat; b_oready = r[5:0];
    end
  endtask

  function automatic vec_t mk(input int d, input logic v, input logic [2:0] s, input logic l,
                              input logic [7:0] dat, input logic [7:0] r, input logic x_rdy,
                              input logic [7:0] x_ov, input logic [63:0] x_od,
                              input logic [7:0] x_ol, input logic x_err, input logic x_busy);
    vec_t t;
    t.d = d; t.v = v; t.s = s; t.l = l; t.dat = dat; t.r = r; t.x_rdy = x_rdy;
    t.x_ov = x_ov; t.x_od = x_od; t.x_ol = x_ol; t.x_err = x_err; t.x_busy = x_busy;
    return t;
  endfunction

  // Random traffic checked against a per-channel expected-beat scoreboard.
  task automatic run_random(input int d, input int ncyc);
    int         nout;
    logic [7:0] rmask;
    bit         lock_mode;
    bit         act;
    int         lsel;
    int         route;
    bit         exp_err;
    bit         have_prev;
    obs_t       o, prev;
    logic [7:0] prev_r;
    logic       v, l;
    logic [2:0] s;
    logic [7:0] dat, r;
    logic [63:0] idle_mask;
    logic [8:0] front;
    nout = (d == 0) ? 8 : 6;
    rmask = (d == 0) ? 8'hFF : 8'h3F;
    lock_mode = (d == 1);
    act = 0; lsel = 0; exp_err = 0; have_prev = 0; prev_r = '0;
    for (int k = 0; k < 8; k++) mq[k].delete();
    for (int c = 0; c < ncyc + 20; c++) begin
      if (c >= ncyc) begin
        v = 1'b0; r = 8'hFF;
      end else begin
        v = ($urandom_range(0, 3) != 0);
        r = 8'($urandom | $urandom);
      end
      s = 3'($urandom_range(0, 7));
      l = ($urandom_range(0, 2) == 0);
      dat = 8'($urandom);
      r = r & rmask;
      drive(d, v, s, l, dat, r);
      @(negedge clk);
      o = observe(d);
      check($sformatf("rnd%0d.c%0d.err_sel", d, c), o.err, exp_err);
      check($sformatf("rnd%0d.c%0d.busy", d, c), o.busy, act);
      check($sformatf("rnd%0d.c%0d.onehot", d, c), ($countones(o.ov) <= 1), 1);
      check($sformatf("rnd%0d.c%0d.in_ready", d, c), o.rdy, ((o.ov & ~r) == 0));
      idle_mask = '1;
      for (int k = 0; k < nout; k++) if (o.ov[k]) idle_mask[k*8 +: 8] = 8'h00;
      check($sformatf("rnd%0d.c%0d.idle_zero", d, c), o.od & idle_mask, 64'h0);
      if (have_prev) begin
        for (int k = 0; k < nout; k++) begin
          if (prev.ov[k] && !prev_r[k]) begin
            check($sformatf("rnd%0d.c%0d.stall%0d", d, c, k),
                  {o.ov[k], o.ol[k], o.od[k*8 +: 8]},
                  {1'b1, prev.ol[k], prev.od[k*8 +: 8]});
          end
        end
      end
      for (int k = 0; k < nout; k++) begin
        if (o.ov[k] && r[k]) begin
          check($sformatf("rnd%0d.c%0d.expect_beat_ch%0d", d, c, k), (mq[k].size() != 0), 1);
          if (mq[k].size() != 0) begin
            front = mq[k].pop_front();
            check($sformatf("rnd%0d.c%0d.beat_ch%0d", d, c, k),
                  {o.ol[k], o.od[k*8 +: 8]}, front);
          end
        end
      end
      exp_err = 0;
      if (v && o.rdy) begin
        route = act ? lsel : int'(s);
        if (route >= nout) exp_err = 1;
        else mq[route].push_back({l, dat});
        if (lock_mode) begin
          if (!act && !l) begin
            act = 1; lsel = int'(s);
          end else if (act && l) begin
            act = 0;
          end
        end
      end
      prev = o; prev_r = r; have_prev = 1;
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < nout; k++)
      check($sformatf("rnd%0d.leftover_ch%0d", d, k), mq[k].size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 8'hFF);
    drive(1, 0, 0, 0, 0, 8'h3F);
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      o = observe(d);
      check($sformatf("reset%0d.out_valid", d), o.ov, 0);
      check($sformatf("reset%0d.out_data", d), o.od, 0);
      check($sformatf("reset%0d.out_last", d), o.ol, 0);
      check($sformatf("reset%0d.err_sel", d), o.err, 0);
      check($sformatf("reset%0d.busy", d), o.busy, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Per-beat routing on A.
    vt.push_back(mk(0, 1, 3, 0, 8'hA5, 8'hFF, 1, 8'h08, sl(3, 8'hA5), 8'h00, 0, 0));
    vt.push_back(mk(0, 1, 6, 0, 8'h5A, 8'hFF, 1, 8'h40, sl(6, 8'h5A), 8'h00, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 8'h00, 8'hFF, 1, 8'h00, 64'h0, 8'h00, 0, 0));
    // Packet lock on B: later selects ignored, even an out-of-range one.
    vt.push_back(mk(1, 1, 2, 0, 8'h11, 8'h3F, 1, 8'h04, sl(2, 8'h11), 8'h00, 0, 1));
    vt.push_back(mk(1, 1, 5, 0, 8'h22, 8'h3F, 1, 8'h04, sl(2, 8'h22), 8'h00, 0, 1));
    vt.push_back(mk(1, 1, 7, 1, 8'h33, 8'h3F, 1, 8'h04, sl(2, 8'h33), 8'h04, 0, 0));
    vt.push_back(mk(1, 0, 0, 0, 8'h00, 8'h3F, 1, 8'h00, 64'h0, 8'h00, 0, 0));
    // Backpressure on A: channel 4 stalls for three cycles with 0x88 waiting.
    vt.push_back(mk(0, 1, 4, 1, 8'h77, 8'hEF, 1, 8'h10, sl(4, 8'h77), 8'h10, 0, 0));
    for (int i = 0; i < 3; i++)
      vt.push_back(mk(0, 1, 1, 1, 8'h88, 8'hEF, 0, 8'h10, sl(4, 8'h77), 8'h10, 0, 0));
    vt.push_back(mk(0, 1, 1, 1, 8'h88, 8'hFF, 1, 8'h02, sl(1, 8'h88), 8'h02, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 8'h00, 8'hFF, 1, 8'h00, 64'h0, 8'h00, 0, 0));
    // Out-of-range single beat on B, then a bad first beat locking a dropped packet.
    vt.push_back(mk(1, 1, 7, 1, 8'h99, 8'h3F, 1, 8'h00, 64'h0, 8'h00, 1, 0));
    vt.push_back(mk(1, 0, 0, 0, 8'h00, 8'h3F, 1, 8'h00, 64'h0, 8'h00, 0, 0));
    vt.push_back(mk(1, 1, 6, 0, 8'hAA, 8'h3F, 1, 8'h00, 64'h0, 8'h00, 1, 1));
    vt.push_back(mk(1, 1, 0, 1, 8'hBB, 8'h3F, 1, 8'h00, 64'h0, 8'h00, 1, 0));
    vt.push_back(mk(1, 0, 0, 0, 8'h00, 8'h3F, 1, 8'h00, 64'h0, 8'h00, 0, 0));
    vt.push_back(mk(1, 1, 1, 1, 8'hCC, 8'h3F, 1, 8'h02, sl(1, 8'hCC), 8'h02, 0, 0));
    vt.push_back(mk(1, 0, 0, 0, 8'h00, 8'h3F, 1, 8'h00, 64'h0, 8'h00, 0, 0));

    foreach (vt[i]) begin
      drive(vt[i].d, vt[i].v, vt[i].s, vt[i].l, vt[i].dat, vt[i].r);
      @(negedge clk);
      o = observe(vt[i].d);
      check($sformatf("vec%0d.in_ready", i), o.rdy, vt[i].x_rdy);
      @(posedge clk);
      #1;
      o = observe(vt[i].d);
      check($sformatf("vec%0d.out_valid", i), o.ov, vt[i].x_ov);
      check($sformatf("vec%0d.out_data", i), o.od, vt[i].x_od);
      check($sformatf("vec%0d.out_last", i), o.ol, vt[i].x_ol);
      check($sformatf("vec%0d.err_sel", i), o.err, vt[i].x_err);
      check($sformatf("vec%0d.busy", i), o.busy, vt[i].x_busy);
    end

    // Full throughput on A: one beat per clock, in order.
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 3'(i % 8), (i == 15), 8'(8'hC0 + i), 8'hFF);
      @(negedge clk);
      check($sformatf("thru%0d.in_ready", i), a_ready, 1);
      @(posedge clk);
      #1;
      check($sformatf("thru%0d.out_valid", i), a_ovalid, 64'(8'h01 << (i % 8)));
      check($sformatf("thru%0d.out_data", i), a_odata, sl(i % 8, 8'(8'hC0 + i)));
    end
    drive(0, 0, 0, 0, 0, 8'hFF);

    // Reset in the middle of a 4-beat packet on B.
    drive(1, 1, 3, 0, 8'h41, 8'h3F);
    @(posedge clk);
    #1;
    check("mid.beat1_valid", b_ovalid, 6'h08);
    check("mid.beat1_busy", b_busy, 1);
    drive(1, 1, 3, 0, 8'h42, 8'h3F);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid.async_valid", b_ovalid, 6'h00);
    check("mid.async_busy", b_busy, 0);
    check("mid.async_data", b_odata, 48'h0);
    drive(1, 0, 0, 0, 0, 8'h3F);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1, 1, 1, 0, 8'h51, 8'h3F);
    @(posedge clk);
    #1;
    check("mid.new1_valid", b_ovalid, 6'h02);
    check("mid.new1_data", b_odata, sl(1, 8'h51));
    check("mid.new1_busy", b_busy, 1);
    drive(1, 1, 4, 1, 8'h52, 8'h3F);
    @(posedge clk);
    #1;
    check("mid.new2_valid", b_ovalid, 6'h02);
    check("mid.new2_data", b_odata, sl(1, 8'h52));
    check("mid.new2_last", b_olast, 6'h02);
    check("mid.new2_busy", b_busy, 0);
    drive(1, 0, 0, 0, 0, 8'h3F);
    @(posedge clk);
    #1;

    run_random(0, 1500);
    run_random(1, 1500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
